// File: rtl/mlp_sequencer.sv
// mlp_sequencer: runs one shared `layer` datapath over L layers of an MLP.
// For each layer it streams M*N weights and M biases from parameter memory
// into holding registers, pulses layer_start, waits for layer_done and then
// feeds layer_y back as the next layer's input.
//
// Handshakes:
//   - start is sampled only in IDLE.
//   - layer_done is sampled only in WAIT.
//   - mem_rdata is valid exactly one cycle after mem_rd and is captured then.
// All of these are level-sampled on the rising edge; there is no back-pressure.
module mlp_sequencer #(
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int L      = 3,
    parameter int MEM_AW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N*16-1:0]     x_in,
    output logic                busy,
    output logic                done,
    output logic [M*16-1:0]     y_out,
    output logic                mem_rd,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [15:0]         mem_rdata,
    output logic                layer_start,
    output logic [N*16-1:0]     layer_x,
    output logic [M*N*16-1:0]   layer_w,
    output logic [M*16-1:0]     layer_b,
    input  logic [M*16-1:0]     layer_y,
    input  logic                layer_done,
    output logic [2:0]          dbg_state
);

    localparam int NW = M * N;           // weight words per layer
    localparam int P  = M * N + M;       // parameter words per layer
    localparam int CW = $clog2(P + 1);   // fetch counter must reach P
    localparam int LW = $clog2(L + 1);

    localparam logic [CW-1:0]     P_C    = CW'(P);
    localparam logic [CW-1:0]     LAST_C = CW'(P - 1);
    localparam logic [LW-1:0]     LLAST  = LW'(L - 1);
    localparam logic [MEM_AW-1:0] STRIDE = MEM_AW'(P);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       rd_cnt_q;    // words requested in this layer
    logic                cap_vld_q;   // a read was issued last cycle
    logic [CW-1:0]       cap_idx_q;   // slot the returning word belongs to
    logic [MEM_AW-1:0]   base_q;      // first word of the current layer
    logic [LW-1:0]       lidx_q;
    logic [N*16-1:0]     act_q;
    logic [M*16-1:0]     y_q;
    logic [M*N*16-1:0]   w_q;
    logic [M*16-1:0]     b_q;
    logic                last_cap;

    assign last_cap    = cap_vld_q && (cap_idx_q == LAST_C);
    assign layer_x     = act_q;
    assign layer_w     = w_q;
    assign layer_b     = b_q;
    assign y_out       = y_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and decoded outputs; reads stop once all P words are requested.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        layer_start = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        dbg_state   = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (rd_cnt_q < P_C) begin
                    mem_rd   = 1'b1;
                    mem_addr = base_q + MEM_AW'(rd_cnt_q);
                end
                if (last_cap) state_d = S_START;
            end
            S_START: begin
                busy        = 1'b1;
                layer_start = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (layer_done) state_d = (lidx_q == LLAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch bookkeeping, activation buffer, layer index and final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q  <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            base_q    <= '0;
            lidx_q    <= '0;
            act_q     <= '0;
            y_q       <= '0;
        end else begin
            cap_vld_q <= mem_rd;
            cap_idx_q <= rd_cnt_q;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        act_q    <= x_in;
                        lidx_q   <= '0;
                        base_q   <= '0;
                        rd_cnt_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem_rd) rd_cnt_q <= rd_cnt_q + CW'(1);
                end
                S_WAIT: begin
                    if (layer_done) begin
                        act_q    <= layer_y;
                        lidx_q   <= lidx_q + LW'(1);
                        base_q   <= base_q + STRIDE;
                        rd_cnt_q <= '0;
                        if (lidx_q == LLAST) y_q <= layer_y;
                    end
                end
                default: ;
            endcase
        end
    end

    // Steer each returning parameter word into its weight or bias slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            b_q <= '0;
        end else if (cap_vld_q) begin
            for (int k = 0; k < NW; k++) begin
                if (cap_idx_q == CW'(k)) w_q[k*16 +: 16] <= mem_rdata;
            end
            for (int j = 0; j < M; j++) begin
                if (cap_idx_q == CW'(NW + j)) b_q[j*16 +: 16] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer with N=M=2, L=3: parameter memory model, behavioural
// layer with programmable delay, and a reference that walks the network.
module tb_mlp_sequencer;

    localparam int N  = 2;
    localparam int M  = 2;
    localparam int L  = 3;
    localparam int AW = 8;
    localparam int NW = M * N;
    localparam int P  = M * N + M;

    logic          clk, rst_n, start;
    logic [31:0]   x_in;
    logic          busy, done;
    logic [31:0]   y_out;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic          layer_start;
    logic [31:0]   layer_x;
    logic [63:0]   layer_w;
    logic [31:0]   layer_b;
    logic [31:0]   layer_y;
    logic          layer_done;
    logic [2:0]    dbg_state;

    mlp_sequencer #(.N(N), .M(M), .L(L), .MEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
        .busy(busy), .done(done), .y_out(y_out),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .layer_start(layer_start), .layer_x(layer_x), .layer_w(layer_w),
        .layer_b(layer_b), .layer_y(layer_y), .layer_done(layer_done),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- parameter memory ----------------
    logic [15:0] mem [0:255];
    initial mem_rdata = 16'h0;
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // ---------------- behavioural layer ----------------
    function automatic logic [31:0] layer_fn(input logic [31:0] x, input logic [63:0] w,
                                             input logic [31:0] b);
        logic [31:0] y;
        for (int j = 0; j < M; j++)
            y[j*16 +: 16] = x[j*16 +: 16] + b[j*16 +: 16] + w[(j*N + j)*16 +: 16];
        return y;
    endfunction

    int          model_delay = 0;
    int          model_cnt = 0;
    logic        model_pend = 1'b0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [31:0] model_y = 32'h0;
    logic [31:0] m_x, m_b;
    logic [63:0] m_w;
    int          ld_cyc_q[$];

    assign layer_done = model_done | spur_done;
    assign layer_y    = model_y;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (!rst_n) begin
            model_pend = 1'b0;
        end else begin
            if (model_pend) begin
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    model_y    = layer_fn(m_x, m_w, m_b);
                    model_pend = 1'b0;
                    ld_cyc_q.push_back(cyc);
                end else begin
                    model_cnt--;
                end
            end
            if (layer_start) begin
                model_pend = 1'b1;
                model_cnt  = model_delay;
                m_x = layer_x;
                m_w = layer_w;
                m_b = layer_b;
            end
        end
    end

    // ---------------- monitor ----------------
    int          rd_cyc_q[$];
    logic [7:0]  addr_q[$];
    int          ls_cyc_q[$];
    logic [31:0] x_q[$];
    logic [63:0] w_q[$];
    logic [31:0] b_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_cyc_q.push_back(cyc);
            addr_q.push_back(mem_addr);
        end
        if (layer_start) begin
            ls_cyc_q.push_back(cyc);
            x_q.push_back(layer_x);
            w_q.push_back(layer_w);
            b_q.push_back(layer_b);
        end
        if (done) done_cnt++;
    end

    // ---------------- scoreboard ----------------
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_x [L];
    logic [63:0] ref_w [L];
    logic [31:0] ref_b [L];
    logic [31:0] ref_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Walk the network straight from memory contents.
    task automatic ref_build(input logic [31:0] x);
        logic [31:0] a;
        a = x;
        for (int l = 0; l < L; l++) begin
            ref_x[l] = a;
            for (int k = 0; k < NW; k++) ref_w[l][k*16 +: 16] = mem[l*P + k];
            for (int j = 0; j < M; j++)  ref_b[l][j*16 +: 16] = mem[l*P + NW + j];
            a = layer_fn(a, ref_w[l], ref_b[l]);
        end
        ref_y = a;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, mem_rd, layer_start, mem_addr}), 64'h0);
        check({tag, "_y"}, 64'(y_out), 64'h0);
        check({tag, "_x"}, 64'(layer_x), 64'h0);
        check({tag, "_w"}, layer_w, 64'h0);
        check({tag, "_b"}, 64'(layer_b), 64'h0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic go(input logic [31:0] x);
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge of FETCH cycle 1; returns at the negedge where done is high.
    task automatic wait_done(input bit inj, output int dcyc);
        bit          seen;
        logic        pb;
        logic [31:0] e;
        seen = 1'b0;
        dcyc = 0;
        pb   = 1'b0;
        for (int i = 2; i < 400 && !seen; i++) begin
            pb = busy;
            @(negedge clk);
            if (inj) begin
                case (i)
                    3:  begin start = 1'b1; x_in = $urandom; end
                    4:  begin start = 1'b0; spur_done = 1'b1; end
                    5:  spur_done = 1'b0;
                    11: start = 1'b1;
                    12: start = 1'b0;
                    default: ;
                endcase
            end
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check("done_seen", 64'(seen), 64'h1);
        if (seen) begin
            check("busy_at_done", 64'(busy), 64'h0);
            check("busy_before_done", 64'(pb), 64'h1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check("y_out", 64'(y_out), 64'(e));
        end
    endtask

    task automatic run(input logic [31:0] x, input int dly, input bit inj, input bit restart);
        int rb, lb, db, dc0, dcyc, first;
        ref_build(x);
        exp_q.push_back(ref_y);
        rb  = rd_cyc_q.size();
        lb  = ls_cyc_q.size();
        db  = ld_cyc_q.size();
        dc0 = done_cnt;
        model_delay = dly;
        go(x);
        wait_done(inj, dcyc);
        if (restart) start = 1'b1;
        check("n_reads", 64'(rd_cyc_q.size() - rb), 64'(L*P));
        check("n_starts", 64'(ls_cyc_q.size() - lb), 64'(L));
        if (rd_cyc_q.size() - rb == L*P && ls_cyc_q.size() - lb == L && ld_cyc_q.size() - db >= L) begin
            for (int l = 0; l < L; l++) begin
                check($sformatf("layer_x_l%0d", l), 64'(x_q[lb+l]), 64'(ref_x[l]));
                check($sformatf("layer_w_l%0d", l), w_q[lb+l], ref_w[l]);
                check($sformatf("layer_b_l%0d", l), 64'(b_q[lb+l]), 64'(ref_b[l]));
                first = rd_cyc_q[rb + l*P];
                for (int i = 0; i < P; i++) begin
                    check($sformatf("addr_l%0d_%0d", l, i), 64'(addr_q[rb + l*P + i]), 64'(l*P + i));
                    check($sformatf("rd_cycle_l%0d_%0d", l, i), 64'(rd_cyc_q[rb + l*P + i] - first), 64'(i));
                end
                check($sformatf("start_gap_l%0d", l), 64'(ls_cyc_q[lb+l] - rd_cyc_q[rb + l*P + P - 1]), 64'd2);
                if (l > 0)
                    check($sformatf("refetch_gap_l%0d", l), 64'(first - ld_cyc_q[db + l - 1]), 64'd1);
            end
            check("done_gap", 64'(dcyc - ld_cyc_q[db + L - 1]), 64'd1);
        end
        @(negedge clk);
        check("done_pulse", 64'(done), 64'h0);
        check("busy_idle", 64'(busy), 64'h0);
        check("done_count", 64'(done_cnt - dc0), 64'd1);
        if (restart) begin
            @(negedge clk);
            start = 1'b0;
            check("restart_accepted", 64'(busy), 64'h1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          dc, dcyc, lb;
        bit          seen;
        logic [63:0] wv;

        rst_n = 1'b0; start = 1'b0; x_in = '0; spur_done = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            x_in  = $urandom;
            spur_done = 1'($urandom_range(0, 1));
            #1 chk_zero("rst");
        end
        @(negedge clk);
        start = 1'b0; spur_done = 1'b0; x_in = '0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_zero("idle");
        check("idle_no_reads", 64'(rd_cyc_q.size()), 64'd0);

        // Addressing and packing: mem[k] = k+1.
        for (int k = 0; k < L*P; k++) mem[k] = 16'(k + 1);
        lb = w_q.size();
        run($urandom, 2, 1'b0, 1'b0);
        check("pack_w0", w_q[lb], 64'h0004_0003_0002_0001);
        check("pack_b0", 64'(b_q[lb]), 64'h0000_0006_0005);
        check("pack_w1", w_q[lb+1], 64'h000A_0009_0008_0007);
        check("pack_b1", 64'(b_q[lb+1]), 64'h0000_000C_000B);

        // Negative word passes through bit-exact.
        mem[2] = 16'hFF80;
        lb = w_q.size();
        run($urandom, 1, 1'b0, 1'b0);
        wv = w_q[lb];
        check("neg_w_slot2", 64'(wv[47:32]), 64'hFF80);

        // Chaining: zero weights, unit biases -> y = x + 1 per layer.
        for (int l = 0; l < L; l++) begin
            for (int k = 0; k < NW; k++) mem[l*P + k] = 16'h0;
            for (int j = 0; j < M; j++)  mem[l*P + NW + j] = 16'h1;
        end
        run({16'd2, 16'd1}, 3, 1'b0, 1'b0);
        check("chain_y_held", 64'(y_out), 64'h0005_0004);

        // Protocol noise during FETCH and WAIT, then zero-delay layer.
        run({16'd2, 16'd1}, 5, 1'b1, 1'b0);
        check("noise_y_held", 64'(y_out), 64'h0005_0004);
        run({16'd2, 16'd1}, 0, 1'b0, 1'b0);
        check("zero_delay_y", 64'(y_out), 64'h0005_0004);

        // start held through DONE is accepted only after returning to IDLE.
        run({16'd7, 16'hFFFE}, 1, 1'b0, 1'b1);
        ref_build({16'd7, 16'hFFFE});
        exp_q.push_back(ref_y);
        wait_done(1'b0, dcyc);
        @(negedge clk);

        // Abort in the WAIT of the second layer.
        for (int k = 0; k < L*P; k++) mem[k] = 16'($urandom);
        lb = ls_cyc_q.size();
        model_delay = 6;
        go($urandom);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ls_cyc_q.size() >= lb + 2) seen = 1'b1;
        end
        check("abort_reach_wait", 64'(seen), 64'h1);
        @(negedge clk);
        @(negedge clk);
        dc = done_cnt;
        rst_n = 1'b0;
        #1 chk_zero("abort");
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - dc), 64'd0);
        rst_n = 1'b1;
        run($urandom, 3, 1'b0, 1'b0);

        // Randomized parameters, inputs and layer delays.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < L*P; k++) mem[k] = 16'($urandom);
            run($urandom, $urandom_range(0, 4), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
